// File: rtl/img_rsz_pxl_capturer_if.sv
// Pixel stream bundle for img_rsz_pxl_capturer.
//   Upstream side : PxlData/PxlX/PxlY with PxlVld/PxlRdy handshake.
//   Downstream    : PxlData_d1/PxlX_d1/PxlY_d1 with PxlVld_d1/PxlRdy_d1.
//   master : the environment (drives input pixels, downstream ready).
//   slave  : the capturer (accepts input pixels, drives buffered pixels).
interface img_rsz_pxl_capturer_if #(
   parameter int IMG_W_IDX_W = 10,
   parameter int IMG_H_IDX_W = 10,
   parameter int COLOR_W     = 8,
   parameter int COLOR_NUM   = 3
);
   logic [COLOR_NUM*COLOR_W-1:0] PxlData, PxlData_d1;
   logic [IMG_W_IDX_W-1:0]       PxlX, PxlX_d1;
   logic [IMG_H_IDX_W-1:0]       PxlY, PxlY_d1;
   logic                         PxlVld, PxlRdy, PxlVld_d1, PxlRdy_d1;

   modport master (
      output PxlData, PxlX, PxlY, PxlVld, PxlRdy_d1,
      input  PxlRdy, PxlData_d1, PxlX_d1, PxlY_d1, PxlVld_d1
   );
   modport slave (
      input  PxlData, PxlX, PxlY, PxlVld, PxlRdy_d1,
      output PxlRdy, PxlData_d1, PxlX_d1, PxlY_d1, PxlVld_d1
   );
endinterface

// File: rtl/img_rsz_pxl_capturer.sv
// Captures one source frame for the resizer: buffers pixels in a FWFT skid
// FIFO, latches the frame size, derives block sizes (size / resized size)
// with a serial restoring divider, tracks expected pixel coordinates and
// counts forwarded resized pixels to detect end of the resized frame.
// Ports:
//   Clk, Reset        : clock, synchronous active-high reset
//   pxl               : pixel stream bundle (slave side)
//   ImgWidth/Height   : source size, sampled with the first pixel
//   FwdRszEn          : one resized pixel forwarded this cycle
//   ProcImgWidth/Height, BlkSzHor/Ver, BlkSzVld : latched size, block size
//   IsFstPxl, PxlCap, CoordErr, RszImgComp      : per-cycle status pulses
module img_rsz_pxl_capturer #(
   parameter int IMG_W_IDX_W = 10,
   parameter int IMG_H_IDX_W = 10,
   parameter int COLOR_W     = 8,
   parameter int COLOR_NUM   = 3,
   parameter int BUF_DEPTH   = 4,
   parameter int RSZ_W       = 32,
   parameter int RSZ_H       = 32,
   parameter bit FWD_SER     = 1'b1
) (
   input  logic                   Clk,
   input  logic                   Reset,
   img_rsz_pxl_capturer_if.slave  pxl,
   input  logic [IMG_W_IDX_W-1:0] ImgWidth,
   input  logic [IMG_H_IDX_W-1:0] ImgHeight,
   input  logic                   FwdRszEn,
   output logic [IMG_W_IDX_W-1:0] ProcImgWidth,
   output logic [IMG_H_IDX_W-1:0] ProcImgHeight,
   output logic [IMG_W_IDX_W-1:0] BlkSzHor,
   output logic [IMG_H_IDX_W-1:0] BlkSzVer,
   output logic                   BlkSzVld,
   output logic                   IsFstPxl,
   output logic                   PxlCap,
   output logic                   CoordErr,
   output logic                   RszImgComp
);
   localparam int DIV_CYC = (IMG_W_IDX_W > IMG_H_IDX_W) ? IMG_W_IDX_W : IMG_H_IDX_W;
   localparam int DCW     = $clog2(DIV_CYC + 1);
   // remainder/trial width wide enough to compare against any 32-bit divisor
   localparam int CW      = (DIV_CYC + 1 > 33) ? DIV_CYC + 1 : 33;
   localparam int PW      = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
   localparam int FW      = $clog2(BUF_DEPTH + 1);
   localparam int ENT_W   = COLOR_NUM*COLOR_W + IMG_W_IDX_W + IMG_H_IDX_W;

   typedef enum logic [1:0] {IDLE, DIV, CAPT, DRAIN} state_t;
   state_t state;

   // ---------------- skid FIFO (first-word fall-through) ----------------
   logic [ENT_W-1:0] mem [BUF_DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic [FW-1:0]    fill;
   logic             full, empty, push, pop;

   assign full  = (fill == FW'(BUF_DEPTH));
   assign empty = (fill == '0);
   assign pxl.PxlRdy    = ~Reset & ~full & ((state == IDLE) | (state == CAPT));
   assign pxl.PxlVld_d1 = ~Reset & ~empty;
   assign push = pxl.PxlVld & pxl.PxlRdy;
   assign pop  = pxl.PxlVld_d1 & pxl.PxlRdy_d1;
   assign {pxl.PxlData_d1, pxl.PxlX_d1, pxl.PxlY_d1} = mem[rd_ptr];

   always_ff @(posedge Clk)
      if (push) mem[wr_ptr] <= {pxl.PxlData, pxl.PxlX, pxl.PxlY};

   always_ff @(posedge Clk) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         fill   <= '0;
      end else begin
         if (push) wr_ptr <= (wr_ptr == PW'(BUF_DEPTH-1)) ? '0 : wr_ptr + 1'b1;
         if (pop)  rd_ptr <= (rd_ptr == PW'(BUF_DEPTH-1)) ? '0 : rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   fill <= fill + 1'b1;
            2'b01:   fill <= fill - 1'b1;
            default: ;
         endcase
      end
   end

   // ---------------- coordinate tracking ----------------
   logic [IMG_W_IDX_W-1:0] cnt_x, w_max, w_clamp;
   logic [IMG_H_IDX_W-1:0] cnt_y, h_max, h_clamp;
   logic                   blk_vld, last_pxl, in_frame, fwd;

   assign w_clamp  = (ImgWidth  == '0) ? IMG_W_IDX_W'(1) : ImgWidth;
   assign h_clamp  = (ImgHeight == '0) ? IMG_H_IDX_W'(1) : ImgHeight;
   // ProcImg* is never 0 (clamped on capture, all-ones after reset)
   assign w_max    = ProcImgWidth  - 1'b1;
   assign h_max    = ProcImgHeight - 1'b1;
   assign last_pxl = (cnt_x == w_max) & (cnt_y == h_max);

   // counters sit at (0,0) in IDLE, so the first pixel is checked too
   assign IsFstPxl = push & (state == IDLE);
   assign PxlCap   = push;
   assign CoordErr = push & ((pxl.PxlX != cnt_x) | (pxl.PxlY != cnt_y));
   assign BlkSzVld = ~Reset & blk_vld;

   assign in_frame = (state == CAPT) | (state == DRAIN);
   assign fwd      = ~Reset & FwdRszEn & in_frame;

   // ---------------- resized-frame completion ----------------
   generate
      if (FWD_SER) begin : g_ser
         localparam int RXW = (RSZ_W > 1) ? $clog2(RSZ_W) : 1;
         localparam int RYW = (RSZ_H > 1) ? $clog2(RSZ_H) : 1;
         logic [RXW-1:0] rx;
         logic [RYW-1:0] ry;
         logic           rx_end;
         assign rx_end     = (rx == RXW'(RSZ_W-1));
         assign RszImgComp = fwd & rx_end & (ry == RYW'(RSZ_H-1));
         always_ff @(posedge Clk) begin
            if (Reset | RszImgComp) begin
               rx <= '0;
               ry <= '0;
            end else if (fwd) begin
               rx <= rx_end ? '0 : rx + 1'b1;
               if (rx_end) ry <= ry + 1'b1;
            end
         end
      end else begin : g_par
         assign RszImgComp = fwd;
      end
   endgenerate

   // ---------------- serial restoring divider ----------------
   // q* start as the dividend and shift out MSB-first while quotient bits
   // shift in at the LSB, so after DIV_CYC steps they hold the quotient.
   logic [DIV_CYC-1:0] qh, qv, qh_nxt, qv_nxt;
   logic [CW-1:0]      rh, rv, rh_nxt, rv_nxt, th, tv;
   logic [DCW-1:0]     div_cnt;

   always_comb begin
      th     = {rh[CW-2:0], qh[DIV_CYC-1]};
      tv     = {rv[CW-2:0], qv[DIV_CYC-1]};
      rh_nxt = th;
      rv_nxt = tv;
      qh_nxt = {qh[DIV_CYC-2:0], 1'b0};
      qv_nxt = {qv[DIV_CYC-2:0], 1'b0};
      if (th >= CW'(RSZ_W)) begin
         rh_nxt    = th - CW'(RSZ_W);
         qh_nxt[0] = 1'b1;
      end
      if (tv >= CW'(RSZ_H)) begin
         rv_nxt    = tv - CW'(RSZ_H);
         qv_nxt[0] = 1'b1;
      end
   end

   // ---------------- control FSM ----------------
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state         <= IDLE;
         ProcImgWidth  <= '1;
         ProcImgHeight <= '1;
         BlkSzHor      <= '0;
         BlkSzVer      <= '0;
         blk_vld       <= 1'b0;
         cnt_x         <= '0;
         cnt_y         <= '0;
         div_cnt       <= '0;
         qh            <= '0;
         qv            <= '0;
         rh            <= '0;
         rv            <= '0;
      end else if (RszImgComp) begin
         // only reachable in CAPT/DRAIN; wins over a coincident last pixel
         state   <= IDLE;
         blk_vld <= 1'b0;
         cnt_x   <= '0;
         cnt_y   <= '0;
      end else begin
         case (state)
            IDLE: if (push) begin
               ProcImgWidth  <= w_clamp;
               ProcImgHeight <= h_clamp;
               cnt_x   <= (w_clamp == IMG_W_IDX_W'(1)) ? '0 : IMG_W_IDX_W'(1);
               cnt_y   <= (w_clamp == IMG_W_IDX_W'(1)) ? IMG_H_IDX_W'(1) : '0;
               qh      <= DIV_CYC'(w_clamp);
               qv      <= DIV_CYC'(h_clamp);
               rh      <= '0;
               rv      <= '0;
               div_cnt <= '0;
               state   <= DIV;
            end
            DIV: begin
               qh      <= qh_nxt;
               qv      <= qv_nxt;
               rh      <= rh_nxt;
               rv      <= rv_nxt;
               div_cnt <= div_cnt + 1'b1;
               if (div_cnt == DCW'(DIV_CYC-1)) begin
                  BlkSzHor <= (qh_nxt == '0) ? IMG_W_IDX_W'(1) : IMG_W_IDX_W'(qh_nxt);
                  BlkSzVer <= (qv_nxt == '0) ? IMG_H_IDX_W'(1) : IMG_H_IDX_W'(qv_nxt);
                  blk_vld  <= 1'b1;
                  state    <= ((ProcImgWidth == IMG_W_IDX_W'(1)) &&
                               (ProcImgHeight == IMG_H_IDX_W'(1))) ? DRAIN : CAPT;
               end
            end
            CAPT: if (push) begin
               if (cnt_x == w_max) begin
                  cnt_x <= '0;
                  cnt_y <= cnt_y + 1'b1;
               end else begin
                  cnt_x <= cnt_x + 1'b1;
               end
               if (last_pxl) state <= DRAIN;
            end
            default: ;
         endcase
      end
   end
endmodule
